seq_frame_sched: RTL and testbench

//  Time-shares one serial sequence detector (x in, z out, clk/rst) between two requesters.

---
 rtl/seq_frame_sched.sv | 168 ++++++++++++++++
 tb/tb_seq_frame_sched.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_frame_sched.sv
// seq_frame_sched
//   Time-shares one serial sequence detector between two requesters. A frame
//   is accepted from one requester (round-robin when both are valid). The
//   detector is then cleared and the frame is shifted into it MSB-first.
//   The cycles with det_z high are counted, and the count is returned tagged
//   with the owning requester's ID.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   req_valid  [1:0]  per-requester frame valid
//   req_data0  frame from requester 0
//   req_data1  frame from requester 1
//   req_ready  [1:0]  one-hot accept (combinational, IDLE only)
//   det_rst    detector reset, one cycle per frame (and during reset)
//   det_x      serial bit to the detector
//   det_z      detector match output
//   res_valid  result valid (DONE)
//   res_ready  result accept
//   res_id     requester that owns the result
//   res_count  number of sampled det_z-high cycles
//   busy       high whenever the scheduler is not idle
module seq_frame_sched #(
   parameter int FRAME_W = 12,
   parameter int DET_LAT = 1,
   localparam int CW = $clog2(FRAME_W + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [1:0]         req_valid,
   input  logic [FRAME_W-1:0] req_data0,
   input  logic [FRAME_W-1:0] req_data1,
   output logic [1:0]         req_ready,
   output logic               det_rst,
   output logic               det_x,
   input  logic               det_z,
   output logic               res_valid,
   input  logic               res_ready,
   output logic               res_id,
   output logic [CW-1:0]      res_count,
   output logic               busy
);

   // j counts cycles from the first SHIFT cycle through the end of DRAIN
   localparam int JW = $clog2(FRAME_W + DET_LAT + 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLR   = 3'd1,
      SHIFT = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t             state_r;
   state_t             state_s;
   logic               ptr_r;
   logic [FRAME_W-1:0] sr_r;
   logic [JW-1:0]      j_r;
   logic [CW-1:0]      count_r;
   logic               id_r;
   logic [1:0]         grant_s;
   logic               xfer_s;
   logic               sample_s;

   // Arbitration: a lone valid requester wins; on contention ptr decides
   always_comb begin
      grant_s = 2'b00;
      if (req_valid == 2'b11) begin
         grant_s = ptr_r ? 2'b10 : 2'b01;
      end else begin
         grant_s = req_valid;
      end
   end

   assign req_ready = (state_r == IDLE && !rst) ? grant_s : 2'b00;
   assign xfer_s    = |(req_valid & req_ready);

   // Only FRAME_W samples are taken, starting DET_LAT cycles into SHIFT
   assign sample_s  = (state_r == SHIFT || state_r == DRAIN) &&
                      (j_r >= JW'(DET_LAT)) && det_z;

   assign det_rst   = rst || (state_r == CLR);
   assign det_x     = (state_r == SHIFT) ? sr_r[FRAME_W-1] : 1'b0;
   assign res_valid = (state_r == DONE);
   assign busy      = (state_r != IDLE);
   assign res_id    = id_r;
   assign res_count = count_r;

   // Next-state logic
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (xfer_s) begin
               state_s = CLR;
            end else begin
               state_s = IDLE;
            end
         end
         CLR: state_s = SHIFT;
         SHIFT: begin
            if (j_r == JW'(FRAME_W - 1)) begin
               state_s = (DET_LAT == 0) ? DONE : DRAIN;
            end else begin
               state_s = SHIFT;
            end
         end
         DRAIN: begin
            if (j_r == JW'(FRAME_W + DET_LAT - 1)) begin
               state_s = DONE;
            end else begin
               state_s = DRAIN;
            end
         end
         DONE: begin
            if (res_ready) begin
               state_s = IDLE;
            end else begin
               state_s = DONE;
            end
         end
         default: state_s = IDLE;
      endcase
   end

   // State register, frame capture, shifting and match counting
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         ptr_r   <= 1'b0;
         sr_r    <= '0;
         j_r     <= '0;
         count_r <= '0;
         id_r    <= 1'b0;
      end else begin
         state_r <= state_s;
         case (state_r)
            IDLE: begin
               if (xfer_s) begin
                  sr_r    <= req_ready[1] ? req_data1 : req_data0;
                  id_r    <= req_ready[1];
                  // Next contention goes to the requester not just served
                  ptr_r   <= req_ready[0];
                  count_r <= '0;
                  j_r     <= '0;
               end
            end
            SHIFT: begin
               sr_r <= {sr_r[FRAME_W-2:0], 1'b0};
               j_r  <= j_r + JW'(1);
               if (sample_s) begin
                  count_r <= count_r + CW'(1);
               end
            end
            DRAIN: begin
               j_r <= j_r + JW'(1);
               if (sample_s) begin
                  count_r <= count_r + CW'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_frame_sched.sv
module tb_seq_frame_sched;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  req_valid = 2'b00;
   logic [11:0] req_data0 = 12'h000;
   logic [11:0] req_data1 = 12'h000;
   logic [1:0]  req_ready;
   logic        det_rst;
   logic        det_x;
   logic        det_z;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic        res_id;
   logic [3:0]  res_count;
   logic        busy;

   int checks = 0;
   int errors = 0;
   int both_ready = 0;

   // Overlapping "0110" Moore detector, cleared by det_rst
   logic [3:0] mh = 4'b0000;
   int         mn = 0;

   always #5 clk = ~clk;

   seq_frame_sched dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_data0(req_data0),
      .req_data1(req_data1), .req_ready(req_ready), .det_rst(det_rst),
      .det_x(det_x), .det_z(det_z), .res_valid(res_valid), .res_ready(res_ready),
      .res_id(res_id), .res_count(res_count), .busy(busy)
   );

   always @(posedge clk) begin
      if (det_rst) begin
         mh <= 4'b0000;
         mn <= 0;
      end else begin
         mh <= {mh[2:0], det_x};
         if (mn < 4) mn <= mn + 1;
      end
   end
   assign det_z = (mn >= 4) && (mh == 4'b0110);

   always @(negedge clk) begin
      if (req_ready == 2'b11) both_ready <= both_ready + 1;
   end

   // Drive one frame until accepted, then observe it up to res_valid
   task automatic send_frame(input logic [1:0] v, input logic [11:0] d0, input logic [11:0] d1,
                             output logic ok, output logic gid, output int lat,
                             output logic [11:0] stream, output int rpulses, output int rfirst);
      int w;
      ok = 1'b0; gid = 1'b0; lat = 0; stream = 12'h000; rpulses = 0; rfirst = -1;
      @(negedge clk);
      req_valid = v; req_data0 = d0; req_data1 = d1;
      #1;
      w = 0;
      while (((req_valid & req_ready) == 2'b00) && w < 40) begin
         @(negedge clk); #1; w++;
      end
      if (w >= 40) begin
         req_valid = 2'b00;
         return;
      end
      gid = req_ready[1];
      @(posedge clk);
      @(negedge clk);
      req_valid = 2'b00; req_data0 = ~d0; req_data1 = ~d1;
      lat = 1;
      while (!res_valid && lat < 40) begin
         if (det_rst) begin
            rpulses++;
            if (rfirst < 0) rfirst = lat;
         end
         if (lat >= 2 && lat <= 13) stream[13 - lat] = det_x;
         @(negedge clk);
         lat++;
      end
      ok = res_valid;
   endtask

   task automatic take_result();
      res_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      res_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = 2'b11;
      repeat (3) @(negedge clk);
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got %b expected 00", req_ready); end
      checks++; if (det_rst !== 1'b1) begin errors++; $display("FAIL reset_det_rst got %b expected 1", det_rst); end
      checks++; if (det_x !== 1'b0) begin errors++; $display("FAIL reset_det_x got %b expected 0", det_x); end
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %b expected 0", res_valid); end
      checks++; if (res_id !== 1'b0 || res_count !== 4'd0) begin errors++; $display("FAIL reset_res got id %b count %0d expected 0/0", res_id, res_count); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
      req_valid = 2'b00; rst = 1'b0;
      @(negedge clk);
      checks++; if (det_rst !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset_release got det_rst %b busy %b expected 0/0", det_rst, busy); end
   endtask

   task automatic test_single_frame();
      logic ok, gid; int lat, rp, rf; logic [11:0] st;
      send_frame(2'b01, 12'b0011_0110_0110, 12'h000, ok, gid, lat, st, rp, rf);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL single_done got %b expected 1", ok); end
      checks++; if (lat != 15) begin errors++; $display("FAIL single_latency got %0d expected 15", lat); end
      checks++; if (st !== 12'b0011_0110_0110) begin errors++; $display("FAIL single_stream got %b expected 001101100110", st); end
      checks++; if (rp != 1 || rf != 1) begin errors++; $display("FAIL single_det_rst got %0d pulses at %0d expected 1 at 1", rp, rf); end
      checks++; if (res_id !== 1'b0) begin errors++; $display("FAIL single_id got %b expected 0", res_id); end
      checks++; if (res_count !== 4'd3) begin errors++; $display("FAIL single_count got %0d expected 3", res_count); end
      take_result();
      checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_release got valid %b busy %b expected 0/0", res_valid, busy); end
   endtask

   task automatic test_no_match();
      logic ok, gid; int lat, rp, rf; logic [11:0] st;
      send_frame(2'b10, 12'h000, 12'hFFF, ok, gid, lat, st, rp, rf);
      checks++; if (ok !== 1'b1 || gid !== 1'b1) begin errors++; $display("FAIL nomatch_grant got ok %b grant %b expected 1/1", ok, gid); end
      checks++; if (res_id !== 1'b1) begin errors++; $display("FAIL nomatch_id got %b expected 1", res_id); end
      checks++; if (res_count !== 4'd0) begin errors++; $display("FAIL nomatch_count got %0d expected 0", res_count); end
      take_result();
   endtask

   task automatic test_arbitration();
      logic ok, gid; int lat, rp, rf; logic [11:0] st;
      logic exp_id; logic [3:0] exp_cnt;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      both_ready = 0;
      for (int i = 0; i < 5; i++) begin
         if (i == 4) repeat (5) @(negedge clk);
         exp_id  = (i % 2 == 1);
         exp_cnt = exp_id ? 4'd3 : 4'd2;
         send_frame(2'b11, 12'b0110_0000_0110, 12'b0110_1101_1000, ok, gid, lat, st, rp, rf);
         checks++; if (ok !== 1'b1 || gid !== exp_id) begin errors++; $display("FAIL arb_grant frame %0d got ok %b grant %b expected 1/%b", i, ok, gid, exp_id); end
         checks++; if (res_id !== exp_id) begin errors++; $display("FAIL arb_id frame %0d got %b expected %b", i, res_id, exp_id); end
         checks++; if (res_count !== exp_cnt) begin errors++; $display("FAIL arb_count frame %0d got %0d expected %0d", i, res_count, exp_cnt); end
         take_result();
      end
      checks++; if (both_ready != 0) begin errors++; $display("FAIL arb_onehot got %0d two-hot cycles expected 0", both_ready); end
   endtask

   task automatic test_backpressure();
      logic ok, gid; int lat, rp, rf; logic [11:0] st;
      send_frame(2'b01, 12'b0011_0110_0110, 12'h000, ok, gid, lat, st, rp, rf);
      req_valid = 2'b11;
      #1;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (res_valid !== 1'b1 || res_id !== 1'b0 || res_count !== 4'd3 || req_ready !== 2'b00 || det_rst !== 1'b0) begin
            errors++;
            $display("FAIL backpressure cycle %0d got valid %b id %b count %0d ready %b det_rst %b expected 1/0/3/00/0",
                     i, res_valid, res_id, res_count, req_ready, det_rst);
         end
         @(negedge clk); #1;
      end
      take_result();
      #1;
      checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_release got valid %b busy %b expected 0/0", res_valid, busy); end
      checks++; if (req_ready === 2'b00) begin errors++; $display("FAIL back_to_back got ready %b expected nonzero", req_ready); end
      req_valid = 2'b00;
   endtask

   task automatic test_reset_mid_shift();
      logic ok, gid; int lat, rp, rf, w, seen; logic [11:0] st;
      @(negedge clk);
      req_valid = 2'b01; req_data0 = 12'b0011_0110_0110;
      #1;
      w = 0;
      while (req_ready !== 2'b01 && w < 40) begin @(negedge clk); #1; w++; end
      checks++; if (w >= 40) begin errors++; $display("FAIL midrst_accept got timeout expected accept"); end
      @(posedge clk);
      @(negedge clk);
      req_valid = 2'b00;
      repeat (7) @(negedge clk);   // now in SHIFT k=6
      rst = 1'b1; req_valid = 2'b01;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || res_valid !== 1'b0 || req_ready !== 2'b00 || det_rst !== 1'b1 || det_x !== 1'b0 || res_id !== 1'b0 || res_count !== 4'd0) begin
         errors++;
         $display("FAIL midrst_outputs got busy %b valid %b ready %b det_rst %b x %b id %b count %0d expected reset values",
                  busy, res_valid, req_ready, det_rst, det_x, res_id, res_count);
      end
      rst = 1'b0; req_valid = 2'b00;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (res_valid || busy) seen++;
      end
      checks++; if (seen != 0) begin errors++; $display("FAIL midrst_no_result got %0d active cycles expected 0", seen); end
      send_frame(2'b01, 12'b0011_0110_0110, 12'h000, ok, gid, lat, st, rp, rf);
      checks++; if (ok !== 1'b1 || res_count !== 4'd3) begin errors++; $display("FAIL midrst_fresh got ok %b count %0d expected 1/3", ok, res_count); end
      take_result();
   endtask

   task automatic test_isolation();
      logic ok, gid; int lat, rp, rf; logic [11:0] st;
      send_frame(2'b01, 12'h003, 12'h000, ok, gid, lat, st, rp, rf);
      checks++; if (ok !== 1'b1 || res_count !== 4'd0) begin errors++; $display("FAIL iso_a got ok %b count %0d expected 1/0", ok, res_count); end
      take_result();
      send_frame(2'b01, 12'h000, 12'h000, ok, gid, lat, st, rp, rf);
      checks++; if (ok !== 1'b1 || res_count !== 4'd0) begin errors++; $display("FAIL iso_b got ok %b count %0d expected 1/0", ok, res_count); end
      take_result();
      send_frame(2'b01, 12'h003, 12'h000, ok, gid, lat, st, rp, rf);
      take_result();
      send_frame(2'b01, 12'hC00, 12'h000, ok, gid, lat, st, rp, rf);
      checks++; if (ok !== 1'b1 || res_count !== 4'd0) begin errors++; $display("FAIL iso_c got ok %b count %0d expected 1/0", ok, res_count); end
      take_result();
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_no_match();
      test_arbitration();
      test_backpressure();
      test_reset_mid_shift();
      test_isolation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
